// File: rtl/load_store_unit.sv
// load_store_unit: sequences one RV32I load/store at a time into a negedge-clocked,
// big-endian, byte-addressed data memory and returns the extended load result.
// Latency: legal access done 2 cycles after accept, illegal request done 1 cycle after accept.
// Backpressure: busy is high in ACCESS and DONE; req_valid seen while busy is dropped, not queued.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word become illegal requests).
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic [1:0]        mem_write_mode,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              op_store;
  logic [2:0]        op_funct3;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              err_q;
  logic [DATA_W-1:0] load_data_q;
  logic              req_legal;
  logic              accept;
  logic [DATA_W-1:0] load_ext;

  assign accept    = (state == IDLE) && req_valid;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = err_q;
  assign load_data = load_data_q;

  // Decide whether the presented request is legal (funct3, optionally alignment).
  always_comb begin
    req_legal = 1'b0;
    if (req_store) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
        default:                                req_legal = 1'b0;
      endcase
    end
`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] = 01 is any halfword op, 10 is any word op.
    if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
      req_legal = 1'b0;
    end
`endif
  end

  // Extend the captured read data; byte/half live in the top lanes (big-endian).
  always_comb begin
    load_ext = '0;
    if (!op_store) begin
      case (op_funct3)
        3'b000:  load_ext = {{(DATA_W-8){mem_rdata[DATA_W-1]}},  mem_rdata[DATA_W-1 -: 8]};
        3'b001:  load_ext = {{(DATA_W-16){mem_rdata[DATA_W-1]}}, mem_rdata[DATA_W-1 -: 16]};
        3'b010:  load_ext = mem_rdata;
        3'b100:  load_ext = {{(DATA_W-8){1'b0}},  mem_rdata[DATA_W-1 -: 8]};
        3'b101:  load_ext = {{(DATA_W-16){1'b0}}, mem_rdata[DATA_W-1 -: 16]};
        default: load_ext = '0;
      endcase
    end
  end

  // State register; reset drops straight to IDLE so memory controls fall asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and memory controls; controls are only non-zero during ACCESS.
  always_comb begin
    state_nxt      = state;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_read       = 1'b0;
    mem_write_mode = 2'b00;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = req_legal ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        mem_addr  = op_addr;
        mem_wdata = op_wdata;
        if (op_store) begin
          case (op_funct3)
            3'b000:  mem_write_mode = 2'b01;
            3'b001:  mem_write_mode = 2'b10;
            3'b010:  mem_write_mode = 2'b11;
            default: mem_write_mode = 2'b00;
          endcase
        end else begin
          mem_read = 1'b1;
        end
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the request on accept and produce the result/error that is shown with done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_store    <= 1'b0;
      op_funct3   <= 3'b000;
      op_addr     <= '0;
      op_wdata    <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      if (accept) begin
        op_store  <= req_store;
        op_funct3 <= req_funct3;
        op_addr   <= req_addr;
        op_wdata  <= req_wdata;
        if (!req_legal) begin
          err_q       <= 1'b1;
          load_data_q <= '0;
        end
      end
      if (state == ACCESS) begin
        err_q       <= 1'b0;
        load_data_q <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed load/store traffic against a byte-array reference.
// A negedge-clocked big-endian memory model stands in for the data memory controller.
// Covers reset state, latency, extension, partial stores, illegal ops, hold-valid throughput, reset abort.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic [1:0]  mem_write_mode;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory seen by the DUT, and the independent reference image of it.
  logic [7:0]  dmem [256];
  logic [7:0]  refm [256];
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  int          n_rd;
  int          n_wr;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .load_data(load_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write_mode(mem_write_mode), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Data memory controller model: acts on the falling edge, big-endian lanes.
  always @(negedge clk) begin
    logic [7:0] ia;
    ia = mem_addr[7:0];
    if (mem_read || mem_write_mode != 2'b00) begin
      check("mem_excl", 32'(mem_read && mem_write_mode != 2'b00), 32'd0);
      check("mem_addr", mem_addr, cur_addr);
    end
    if (mem_read) begin
      n_rd++;
      mem_rdata <= {dmem[ia], dmem[8'(ia + 1)], dmem[8'(ia + 2)], dmem[8'(ia + 3)]};
    end
    if (mem_write_mode != 2'b00) begin
      n_wr++;
      check("mem_wdata", mem_wdata, cur_wdata);
    end
    case (mem_write_mode)
      2'b01: dmem[ia] = mem_wdata[7:0];
      2'b10: begin
        dmem[ia]           = mem_wdata[15:8];
        dmem[8'(ia + 1)]   = mem_wdata[7:0];
      end
      2'b11: begin
        dmem[ia]           = mem_wdata[31:24];
        dmem[8'(ia + 1)]   = mem_wdata[23:16];
        dmem[8'(ia + 2)]   = mem_wdata[15:8];
        dmem[8'(ia + 3)]   = mem_wdata[7:0];
      end
      default: ;
    endcase
  end

  function automatic logic op_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    if (st) ok = (f3 <= 3'd2);
    else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) ok = 1'b0;
    if (f3 == 3'd2 && (a % 4 != 0)) ok = 1'b0;
`endif
    return ok;
  endfunction

  // One transaction end to end: latency, result, error, one-cycle done, hold, access counts.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] ld);
    logic        legal;
    logic [31:0] w;
    logic [31:0] exp;
    logic [7:0]  b;
    logic        errv;
    int          lat;
    legal = op_legal(st, f3, a);
    b = a[7:0];
    w = {refm[b], refm[8'(b + 1)], refm[8'(b + 2)], refm[8'(b + 3)]};
    case (f3)
      3'd0:    exp = 32'($signed(w[31:24]));
      3'd1:    exp = 32'($signed(w[31:16]));
      3'd2:    exp = w;
      3'd4:    exp = {24'd0, w[31:24]};
      3'd5:    exp = {16'd0, w[31:16]};
      default: exp = 32'd0;
    endcase
    if (st) exp = 32'd0;
    cur_addr = a; cur_wdata = wd; n_rd = 0; n_wr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_latency", 32'(lat), legal ? 32'd2 : 32'd1);
    check("err", 32'(err), 32'(!legal));
    if (legal) check("load_data", load_data, exp);
    ld = load_data;
    errv = err;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("hold_load_data", load_data, ld);
    check("hold_err", 32'(err), 32'(errv));
    check("n_reads", 32'(n_rd), 32'(legal && !st));
    check("n_writes", 32'(n_wr), 32'(legal && st));
    if (legal && st) begin
      case (f3)
        3'd0: refm[b] = wd[7:0];
        3'd1: begin refm[b] = wd[15:8]; refm[8'(b + 1)] = wd[7:0]; end
        default: begin
          refm[b] = wd[31:24]; refm[8'(b + 1)] = wd[23:16];
          refm[8'(b + 2)] = wd[15:8]; refm[8'(b + 3)] = wd[7:0];
        end
      endcase
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ld;
    int pulses;
    for (int i = 0; i < 256; i++) begin dmem[i] = 8'h00; refm[i] = 8'h00; end
    mem_rdata = 32'd0; n_rd = 0; n_wr = 0; cur_addr = 0; cur_wdata = 0;
    reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_mem_ctrl", {29'd0, mem_read, mem_write_mode}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // Store word then read back.
    do_op(1'b1, 3'd2, 32'h4, 32'hDEADBEEF, ld);
    do_op(1'b0, 3'd2, 32'h4, 32'h0, ld);
    check("sw_lw", ld, 32'hDEADBEEF);
    // Sign/zero extension from word 0x80F00000 at 0x8.
    do_op(1'b1, 3'd2, 32'h8, 32'h80F00000, ld);
    do_op(1'b0, 3'd0, 32'h8, 32'h0, ld); check("lb", ld, 32'hFFFFFF80);
    do_op(1'b0, 3'd4, 32'h8, 32'h0, ld); check("lbu", ld, 32'h00000080);
    do_op(1'b0, 3'd1, 32'h8, 32'h0, ld); check("lh", ld, 32'hFFFF80F0);
    do_op(1'b0, 3'd5, 32'h8, 32'h0, ld); check("lhu", ld, 32'h000080F0);
    // Partial stores.
    do_op(1'b1, 3'd2, 32'h0, 32'h11223344, ld);
    do_op(1'b1, 3'd0, 32'h1, 32'h000000AA, ld);
    do_op(1'b0, 3'd2, 32'h0, 32'h0, ld); check("sb_merge", ld, 32'h11AA3344);
    do_op(1'b1, 3'd1, 32'h2, 32'h0000BEEF, ld);
    do_op(1'b0, 3'd2, 32'h0, 32'h0, ld); check("sh_merge", ld, 32'h11AABEEF);
    // Illegal funct3 load and store.
    do_op(1'b0, 3'd3, 32'h0, 32'h0, ld);
    check("illegal_err", 32'(err), 32'd1);
    do_op(1'b1, 3'd4, 32'h0, 32'h12345678, ld);
    // Misaligned word.
    do_op(1'b0, 3'd2, 32'h6, 32'h0, ld);
`ifdef LSU_MISALIGN_TRAP_EN
    check("misalign_err", 32'(err), 32'd1);
`else
    check("misalign_err", 32'(err), 32'd0);
    check("misalign_data", ld, {refm[6], refm[7], refm[8], refm[9]});
`endif

    // Random traffic, including upper address bits and illegal codes.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = $urandom();
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(), ld);
    end

    // req_valid held high: one accept per 3 cycles.
    cur_addr = 32'h10; cur_wdata = 32'd0; n_rd = 0; n_wr = 0; pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    req_valid = 1'b0;
    check("held_valid_done_pulses", 32'(pulses), 32'd4);
    check("held_valid_reads", 32'(n_rd), 32'd4);
    for (int c = 0; c < 5 && busy; c++) @(posedge clk);

    // Reset during ACCESS of a store word aborts it.
    cur_addr = 32'h20; cur_wdata = 32'hCAFEF00D; n_rd = 0; n_wr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_mode_before", 32'(mem_write_mode), 32'd3);
    reset_n = 1'b0;
    #1;
    check("abort_mode", 32'(mem_write_mode), 32'd0);
    check("abort_read", 32'(mem_read), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_load_data", load_data, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_mem_wdata", mem_wdata, 32'd0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_no_write", 32'(n_wr), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    do_op(1'b0, 3'd2, 32'h20, 32'h0, ld);
    check("abort_mem_unchanged", ld, {refm[32], refm[33], refm[34], refm[35]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequences single load/store requests from the execute stage into the byte-addressed data memory controller, and returns extended load results to writeback. Requests are latched, then memory controls are driven for one full clock cycle so the negedge-clocked memory completes the access mid-cycle. Read data is captured on the following posedge and sign- or zero-extended per RV32I `funct3`. The unit stalls the core with `busy` while an access is in flight.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (fixed 32; byte/half lane rules assume it)

- `clk` in 1: single clock, rising-edge logic
- `reset_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: request strobe from execute
- `req_store` in 1: 1 = store, 0 = load
- `req_funct3` in 3: RV32I width/sign code
- `req_addr` in 32: effective byte address
- `req_wdata` in 32: store data (rs2)
- `busy` out 1: access in flight; new requests ignored
- `done` out 1: one-cycle completion pulse
- `err` out 1: valid with `done`; illegal funct3 (or misaligned when trapping)
- `load_data` out 32: extended load result, valid with `done`
- `mem_addr` out 32, `mem_wdata` out 32, `mem_read` out 1, `mem_write_mode` out 2: to data memory controller (00 none, 01 byte, 10 half, 11 word)
- `mem_rdata` in 32: from data memory controller

## Operation
- Memory contract: big-endian byte lanes. The byte at `addr` is `rdata[31:24]`, and word reads return `{m[a],m[a+1],m[a+2],m[a+3]}`. Byte store writes `wdata[7:0]` to `a`. Half store writes `wdata[15:8]` to `a` and `[7:0]` to `a+1`. Word store writes MSB first.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: on posedge with `req_valid`, latch op/addr/wdata/funct3.
    - If legal: go to ACCESS.
    - If illegal: go to DONE with `err`=1 and no memory access.
  - ACCESS: drive `mem_addr` = latched addr and `mem_wdata` = latched wdata.
    - Loads: `mem_read`=1, `mem_write_mode`=00.
    - Stores: `mem_read`=0, `mem_write_mode` = 01/10/11 for funct3 000/001/010.
    - Next posedge: capture `mem_rdata`, go to DONE.
  - DONE: `done`=1 for exactly one cycle; memory controls return to 0; go to IDLE.
- Legal load funct3 and result:
  - 000 LB: sext `rdata[31:24]`
  - 001 LH: sext `rdata[31:16]`
  - 010 LW: `rdata`
  - 100 LBU: zext `rdata[31:24]`
  - 101 LHU: zext `rdata[31:16]`
- Legal store funct3: 000, 001, 010. All other codes are illegal.
- Stores: `load_data` = 0 at `done`.
- `busy` = 1 in ACCESS and DONE. `req_valid` seen in those states is dropped, not queued.
- `mem_read` and a nonzero `mem_write_mode` are never asserted together.
- Addresses pass through unmodified, so wrap at 0xFFFFFFFF is the memory's concern.

## Timing
- Reset: all outputs 0, state IDLE. `reset_n` low mid-ACCESS aborts immediately: memory controls drop to 0 asynchronously and no `done` is issued.
- Latency: request accepted at edge N, memory acts at negedge in cycle N+1, `done` high during cycle N+2. Illegal requests show `done` during cycle N+1.
- Throughput: one access per 3 cycles. A request presented while `done`=1 is ignored; the earliest next accept is the edge ending DONE+1.
- `load_data` and `err` hold their values after `done` until the next `done` or reset.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: halfword with `addr[0]`≠0, or word with `addr[1:0]`≠0, counts as illegal. It goes IDLE→DONE with `err`=1 and issues no memory access.
- `LSU_MISALIGN_TRAP_EN` undefined: any address is issued unchanged (byte-addressed memory tolerates it), and `err` is set only for illegal funct3.

## Test plan
- Store word: SW addr 0x4 data 0xDEADBEEF, then LW 0x4 → `load_data` 0xDEADBEEF with `done` 2 cycles after accept, `err`=0.
- Sign/zero extension: memory word at 0x8 = 0x80F00000. LB 0x8 → 0xFFFFFF80; LBU → 0x00000080; LH → 0xFFFF80F0; LHU → 0x000080F0.
- Partial stores: SW 0x0 0x11223344, then SB 0x1 data 0x000000AA, then LW 0x0 → 0x11AA3344. SH 0x2 data 0x0000BEEF, then LW 0x0 → 0x11AABEEF.
- Illegal/busy: funct3 011 load → `done` next cycle with `err`=1 and no `mem_read` pulse. Also, `req_valid` held high continuously → exactly one accept per 3 cycles.
- Reset mid-access: drop `reset_n` during ACCESS of SW → `mem_write_mode` goes 0 at once, no `done`, all outputs 0.
- Misalign (macro on): LW 0x6 → `err`=1, no memory access. With the macro off: the access is issued and `err`=0.
